adder_subtractor: RTL and testbench
===================================

// Module: adder_subtractor
// PURPOSE
//   Clocked ripple adder/subtractor for the RISC-V datapath. Adds or subtracts B
//   from A with carry/borrow-in. Registers result and carry/borrow-out on the
//   rising clock edge. Default width is 1 bit, so it serves as the bit-slice
//   primitive. Wider instances are used for ALU experiments.
// PARAMETERS
//   WIDTH  1  operand/result width in bits (>=1)
// PORTS
//   clk     in   1      system clock; all state updates on rising edge
//   rst     in   1      synchronous, active-high reset
//   A       in   WIDTH  operand A (unsigned bit vector)
//   B       in   WIDTH  operand B (unsigned bit vector)
//   op      in   1      0 = add (OP_ADD), 1 = subtract (OP_SUB)
//   cin     in   1      add: carry-in; subtract: borrow-in
//   result  out  WIDTH  registered sum/difference, low WIDTH bits
//   cout    out  1      registered carry-out (add) / borrow-out (subtract)
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous and active-high.
//   - Reset: on a rising clk with rst=1, result <= '0 and cout <= 0.
//     rst takes priority over any computation in that cycle.
//   - No handshake. Inputs are sampled every rising clk edge when rst=0.
//     Outputs reflect the inputs sampled on that edge; latency = 1 cycle.
//   - Outputs hold their value between edges and change only at rising clk.
//   - op=0 (add): {cout,result} <= A + B + cin. Computed at WIDTH+1 bits, zero-extended.
//   - op=1 (subtract): result <= A - B - cin (mod 2^WIDTH).
//     Core form is A + ~B + ~cin at WIDTH+1 bits.
//     cout <= 1 iff borrow occurred, i.e. (A < B + cin) unsigned.
//     cout is the inverted carry of that internal sum, so cout=1 means borrow.
//   - Wrap-around: the result is always truncated to WIDTH bits; overflow is visible only via cout.
//   - Boundaries:
//     - all-ones + all-ones + 1 -> result all-ones, cout=1.
//     - 0 - 0 - 1 -> result all-ones, cout=1.
//     - A == B with cin=0 -> result 0, cout=0.
//   - Reset asserted mid-stream: the next edge clears outputs. The first edge
//     after rst deasserts registers the inputs present at that edge.
//   - X/Z on inputs is not sanitised; it propagates to the outputs.
// STRUCTURE
//   - Package adder_subtractor_pkg:
//     - localparam logic OP_ADD = 1'b0, OP_SUB = 1'b1.
//     - typedef logic op_t.
//   - Sub-module adder_subtractor_core (combinational, WIDTH-parameterised):
//     - generate-loop ripple chain of full-adder cells.
//     - B-input XORed with op; carry-in = cin ^ op.
//     - Final carry XORed with op to form cout.
//   - Top: instantiates core and holds the output registers with synchronous reset.
// TESTING
//   1. rst=1 for 2 edges with A=1,B=1,op=1,cin=0 -> result=0, cout=0 after each edge.
//   2. WIDTH=1, rst=0, A=1,B=1,op=1,cin=0 -> next edge result=0, cout=0.
//      Then A=0,B=1,op=1,cin=0 -> result=1, cout=1 (borrow).
//   3. WIDTH=1: A=0,B=1,op=0,cin=0 -> result=1, cout=0.
//      A=1,B=1,op=0,cin=1 -> result=1, cout=1.
//   4. WIDTH=8: A=8'hFF,B=8'h01,op=0,cin=0 -> result=8'h00, cout=1.
//      A=8'h05,B=8'h07,op=1,cin=0 -> result=8'hFE, cout=1.
//   5. Latency: change inputs every cycle for 10 random cycles.
//      Outputs must equal the model of the inputs from the previous edge, with no combinational path.
//   6. rst asserted for one edge mid-stream -> outputs 0 on that edge.
//      The following edge must show the fresh computation.

Source files
------------

// File: rtl/adder_subtractor_pkg.sv
// Shared definitions for the adder/subtractor slice.
// Operation encoding used by the core and the top.
package adder_subtractor_pkg;

  typedef logic op_t;

  localparam op_t OP_ADD = 1'b0;
  localparam op_t OP_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor_core.sv
// Combinational ripple-carry adder/subtractor.
// Subtract is A + ~B + ~cin; cout is flipped so 1 means borrow.
import adder_subtractor_pkg::*;

module adder_subtractor_core #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  op_t              op,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_eff;

  // Borrow-in becomes an inverted carry-in when subtracting.
  assign carry[0] = cin ^ op;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      assign b_eff[i]   = B[i] ^ op;
      assign sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
      assign carry[i+1] = (A[i] & b_eff[i])
                        | (carry[i] & (A[i] ^ b_eff[i]));
    end
  endgenerate

  // A missing carry out of the subtract sum is a borrow.
  assign cout = carry[WIDTH] ^ op;

endmodule

// File: rtl/adder_subtractor.sv
// Registered adder/subtractor with one cycle of latency.
// Synchronous active-high reset clears result and cout.
import adder_subtractor_pkg::*;

module adder_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH-1:0] sum;
  logic             core_cout;

  adder_subtractor_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A    (A),
    .B    (B),
    .op   (op),
    .cin  (cin),
    .sum  (sum),
    .cout (core_cout)
  );

  // Capture the combinational result every edge; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cout   <= 1'b0;
    end else begin
      result <= sum;
      cout   <= core_cout;
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed bench for adder_subtractor at WIDTH=1 and WIDTH=8.
// Checks compare {cout,result} with bench-computed values.
module tb_adder_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, op1, cin1;
  logic       r1, c1;
  logic [7:0] a8, b8;
  logic       op8, cin8;
  logic [7:0] r8;
  logic       c8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_subtractor #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .A      (a1),
    .B      (b1),
    .op     (op1),
    .cin    (cin1),
    .result (r1),
    .cout   (c1)
  );

  adder_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .A      (a8),
    .B      (b8),
    .op     (op8),
    .cin    (cin8),
    .result (r8),
    .cout   (c8)
  );

  function automatic logic [8:0] model8(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       o,
    input logic       c
  );
    logic [8:0] bc;
    if (!o) return {1'b0, a} + {1'b0, b} + {8'd0, c};
    bc = {1'b0, b} + {8'd0, c};
    return {(bc > {1'b0, a}), a - b - {7'd0, c}};
  endfunction

  task automatic chk(
    input string      tag,
    input logic [8:0] got,
    input logic [8:0] exp
  );
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set1(input logic a, b, o, c);
    a1 = a; b1 = b; op1 = o; cin1 = c;
  endtask

  task automatic set8(input logic [7:0] a, b, input logic o, c);
    a8 = a; b8 = b; op8 = o; cin8 = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp;
    logic [8:0] prev;

    rst = 1'b1;
    set1(1'b1, 1'b1, 1'b1, 1'b0);
    set8(8'hFF, 8'hFF, 1'b0, 1'b1);

    tick();
    chk("rst_e1_w1", {7'd0, c1, r1}, 9'h000);
    chk("rst_e1_w8", {c8, r8}, 9'h000);
    tick();
    chk("rst_e2_w1", {7'd0, c1, r1}, 9'h000);
    chk("rst_e2_w8", {c8, r8}, 9'h000);

    rst = 1'b0;
    tick();
    chk("w1_sub_1m1", {7'd0, c1, r1}, 9'h000);
    chk("w8_ff_ff_1", {c8, r8}, 9'h1FF);

    set1(1'b0, 1'b1, 1'b1, 1'b0);
    set8(8'h00, 8'h00, 1'b1, 1'b1);
    tick();
    chk("w1_sub_0m1", {7'd0, c1, r1}, 9'h003);
    chk("w8_0m0m1", {c8, r8}, 9'h1FF);

    set1(1'b0, 1'b1, 1'b0, 1'b0);
    set8(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    chk("w1_add_0p1", {7'd0, c1, r1}, 9'h001);
    chk("w8_ff_p_01", {c8, r8}, 9'h100);

    set1(1'b1, 1'b1, 1'b0, 1'b1);
    set8(8'h05, 8'h07, 1'b1, 1'b0);
    tick();
    chk("w1_add_111", {7'd0, c1, r1}, 9'h003);
    chk("w8_05m07", {c8, r8}, 9'h1FE);

    set1(1'b0, 1'b0, 1'b1, 1'b1);
    set8(8'h5A, 8'h5A, 1'b1, 1'b0);
    tick();
    chk("w1_sub_000b", {7'd0, c1, r1}, 9'h003);
    chk("w8_eq_sub", {c8, r8}, 9'h000);

    set8(8'h80, 8'h7F, 1'b1, 1'b1);
    tick();
    chk("w8_80m7f_1", {c8, r8}, 9'h000);

    set8(8'h10, 8'h20, 1'b0, 1'b1);
    tick();
    chk("w8_10p20_1", {c8, r8}, 9'h031);
    prev = 9'h031;

    for (int i = 0; i < 10; i++) begin
      set8(8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
      exp = model8(a8, b8, op8, cin8);
      #2;
      chk("rnd_hold", {c8, r8}, prev);
      tick();
      chk("rnd_lat", {c8, r8}, exp);
      prev = exp;
    end

    set8(8'hC3, 8'h3C, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_w8", {c8, r8}, 9'h000);
    chk("mid_rst_w1", {7'd0, c1, r1}, 9'h000);

    rst = 1'b0;
    set8(8'h01, 8'h02, 1'b1, 1'b0);
    set1(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_w8", {c8, r8}, 9'h1FF);
    chk("post_rst_w1", {7'd0, c1, r1}, 9'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
